// File: rtl/calc_op_sequencer.sv
// Command sequencer for the 4-function calculator: single-cycle ADD/SUB/MUL,
// restoring divide one quotient bit per cycle, and an internal memory register M.
module calc_op_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             use_mem_a,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             err,
   output logic [WIDTH-1:0] mem_value,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_SUB    = 3'd1;
   localparam logic [2:0] OP_MUL    = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd3;
   localparam logic [2:0] OP_MPLUS  = 3'd4;
   localparam logic [2:0] OP_MMINUS = 3'd5;
   localparam logic [2:0] OP_MR     = 3'd6;
   localparam logic [2:0] OP_MC     = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIVIDE, S_DONE} state_t;

   state_t            state;
   state_t            state_n;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  mem_q;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH-1:0]  rem_q;
   logic              err_q;
   logic [CW-1:0]     bit_cnt;

   logic              div_start;
   logic [WIDTH:0]    sum_w;
   logic [WIDTH:0]    diff_w;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]  exec_result;
   logic [WIDTH-1:0]  exec_mem;
   logic              exec_err;
   logic [WIDTH:0]    trial;
   logic              div_ge;
   logic [WIDTH-1:0]  div_sub;

   // A zero divisor skips the DIVIDE phase and reports the error straight from EXEC.
   assign div_start = (op_q == OP_DIV) && (b_q != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (cmd_valid) state_n = S_EXEC;
         S_EXEC:   state_n = div_start ? S_DIVIDE : S_DONE;
         S_DIVIDE: if (bit_cnt == LAST_BIT) state_n = S_DONE;
         S_DONE:   if (res_ready) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      exec_result = '0;
      exec_err    = 1'b0;
      exec_mem    = mem_q;
      sum_w       = '0;
      diff_w      = '0;
      prod        = '0;
      case (op_q)
         OP_ADD: begin
            sum_w       = {1'b0, a_q} + {1'b0, b_q};
            exec_result = sum_w[WIDTH-1:0];
            exec_err    = sum_w[WIDTH];
         end
         OP_SUB: begin
            diff_w      = {1'b0, a_q} - {1'b0, b_q};
            exec_result = diff_w[WIDTH-1:0];
            exec_err    = diff_w[WIDTH];
         end
         OP_MUL: begin
            prod        = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
            exec_result = prod[WIDTH-1:0];
            exec_err    = |prod[2*WIDTH-1:WIDTH];
         end
         OP_DIV:   exec_err = 1'b1;
         OP_MPLUS: begin
            sum_w       = {1'b0, mem_q} + {1'b0, a_q};
            exec_mem    = sum_w[WIDTH-1:0];
            exec_result = sum_w[WIDTH-1:0];
            exec_err    = sum_w[WIDTH];
         end
         OP_MMINUS: begin
            diff_w      = {1'b0, mem_q} - {1'b0, a_q};
            exec_mem    = diff_w[WIDTH-1:0];
            exec_result = diff_w[WIDTH-1:0];
            exec_err    = diff_w[WIDTH];
         end
         OP_MR:   exec_result = mem_q;
         OP_MC:   exec_mem    = '0;
         default: exec_err    = 1'b0;
      endcase
   end

   // Restoring step: the partial remainder never exceeds the divisor, so W bits hold it.
   assign trial   = {rem_q, quo_q[WIDTH-1]};
   assign div_ge  = (trial >= {1'b0, b_q});
   assign div_sub = trial[WIDTH-1:0] - b_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mem_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         bit_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q <= cmd_op;
                  a_q  <= use_mem_a ? mem_q : cmd_a;
                  b_q  <= cmd_b;
               end
            end
            S_EXEC: begin
               if (div_start) begin
                  quo_q   <= a_q;
                  rem_q   <= '0;
                  err_q   <= 1'b0;
                  bit_cnt <= '0;
               end else begin
                  quo_q <= exec_result;
                  rem_q <= '0;
                  err_q <= exec_err;
                  mem_q <= exec_mem;
               end
            end
            S_DIVIDE: begin
               quo_q   <= {quo_q[WIDTH-2:0], div_ge};
               rem_q   <= div_ge ? div_sub : trial[WIDTH-1:0];
               bit_cnt <= bit_cnt + 1'b1;
            end
            default: begin
               quo_q <= quo_q;
            end
         endcase
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign res_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign result    = quo_q;
   assign remainder = rem_q;
   assign err       = err_q;
   assign mem_value = mem_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: a plain-arithmetic calculator model predicts
// each result at accept time, a monitor checks every presented result in order.
module tb_calc_op_sequencer;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = '0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic         use_mem_a = 1'b0;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic [W-1:0] remainder;
   logic         err;
   logic [W-1:0] mem_value;
   logic         busy;

   int           rr_mode = 0;
   logic         rand_bit = 1'b1;
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   int           model_mem = 0;

   typedef struct {
      int res;
      int rem;
      int err;
      int mem;
      int lat;
      int acc;
      bit gap;
   } exp_t;

   exp_t sb[$];

   calc_op_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .use_mem_a(use_mem_a),
      .res_valid(res_valid), .res_ready(res_ready),
      .result(result), .remainder(remainder), .err(err),
      .mem_value(mem_value), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));

   // Mode 0: always ready, 1: random backpressure, 2: stalled.
   assign res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? rand_bit : 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Calculator behaviour from the arithmetic rules; updates the model memory.
   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int   s;
      e.rem = 0;
      e.err = 0;
      e.res = 0;
      case (op)
         0: begin s = a + b; e.res = s % MOD; e.err = int'(s >= MOD); end
         1: begin e.res = (a - b + MOD) % MOD; e.err = int'(a < b); end
         2: begin s = a * b; e.res = s % MOD; e.err = int'(s >= MOD); end
         3: begin
            if (b == 0) e.err = 1;
            else begin e.res = a / b; e.rem = a % b; end
         end
         4: begin s = model_mem + a; e.err = int'(s >= MOD); model_mem = s % MOD; e.res = model_mem; end
         5: begin e.err = int'(model_mem < a); model_mem = (model_mem - a + MOD) % MOD; e.res = model_mem; end
         6: e.res = model_mem;
         default: model_mem = 0;
      endcase
      e.mem = model_mem;
      e.lat = (op == 3 && b != 0) ? W + 2 : 2;
      e.acc = 0;
      e.gap = 1'b0;
      return e;
   endfunction

   // Drives one command (just after a clock edge) until it is accepted.
   task automatic applyStimulus(input int op, input int a, input int b, input bit um,
                                input bit track, input bit gap);
      exp_t e;
      bit   done = 1'b0;
      cmd_op    = 3'(op);
      cmd_a     = W'(a);
      cmd_b     = W'(b);
      use_mem_a = um;
      cmd_valid = 1'b1;
      for (int t = 0; t < 100 && !done; t++) begin
         if (cmd_ready) begin
            if (track) begin
               e     = model(op, um ? model_mem : a, b);
               e.acc = cyc + 1;
               e.gap = gap;
               sb.push_back(e);
            end
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic idleCycles(input int n);
      cmd_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: latency is counted in edges inclusive of the accept edge.
   initial begin : monitor
      exp_t e;
      bit   prev_v = 1'b0;
      int   last_acc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (res_valid) begin
               if (sb.size() == 0) begin
                  if (!prev_v) checkOutput("unexpected_result", 1, 0);
               end else begin
                  e = sb[0];
                  if (!prev_v) begin
                     checkOutput("latency", cyc - e.acc + 1, e.lat);
                     if (e.gap) checkOutput("accept_gap", e.acc - last_acc, 3);
                  end
                  checkOutput("result", int'(result), e.res);
                  checkOutput("remainder", int'(remainder), e.rem);
                  checkOutput("err", int'(err), e.err);
                  checkOutput("mem_value", int'(mem_value), e.mem);
                  checkOutput("ready_in_done", int'(cmd_ready), 0);
                  if (res_ready) begin
                     last_acc = e.acc;
                     void'(sb.pop_front());
                  end
               end
            end
            prev_v = res_valid && !res_ready;
         end
      end
   end

   initial begin : main
      int wait_cnt;
      int op;
      int a;
      int b;
      bit um;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #4;
      checkOutput("reset_cmd_ready", int'(cmd_ready), 1);
      checkOutput("reset_res_valid", int'(res_valid), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_mem", int'(mem_value), 0);
      checkOutput("reset_result", int'(result), 0);
      checkOutput("reset_err", int'(err), 0);
      @(posedge clk);
      #1;

      // Load M, then reset in the middle of a divide.
      applyStimulus(4, 5, 0, 1'b0, 1'b1, 1'b0);
      idleCycles(3);
      applyStimulus(3, 13, 3, 1'b0, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      model_mem = 0;
      #2;
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_res_valid", int'(res_valid), 0);
      checkOutput("midrst_mem", int'(mem_value), 0);
      checkOutput("midrst_cmd_ready", int'(cmd_ready), 1);
      idleCycles(10);

      // Directed arithmetic and memory chain.
      applyStimulus(0, 9, 8, 1'b0, 1'b1, 1'b0);
      applyStimulus(1, 3, 5, 1'b0, 1'b1, 1'b0);
      applyStimulus(2, 3, 5, 1'b0, 1'b1, 1'b0);
      applyStimulus(2, 4, 4, 1'b0, 1'b1, 1'b0);
      applyStimulus(3, 13, 3, 1'b0, 1'b1, 1'b0);
      applyStimulus(3, 7, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(7, 0, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(4, 9, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(4, 9, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5, 3, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(6, 0, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1, 1'b1, 1'b1, 1'b0);
      idleCycles(4);

      // Backpressure: result held for five cycles, stray command ignored.
      rr_mode = 2;
      applyStimulus(3, 15, 4, 1'b0, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      wait_cnt = 0;
      while (!res_valid && wait_cnt < 20) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      if (!res_valid) checkOutput("stall_timeout", 0, 1);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            cmd_op = 3'd0; cmd_a = 4'd1; cmd_b = 4'd1; use_mem_a = 1'b0; cmd_valid = 1'b1;
            checkOutput("stall_cmd_ready", int'(cmd_ready), 0);
         end
         if (k == 2) cmd_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      rr_mode = 0;
      @(posedge clk);
      #1;
      checkOutput("release_cmd_ready", int'(cmd_ready), 1);
      checkOutput("release_busy", int'(busy), 0);
      idleCycles(2);

      // Back-to-back ADDs with cmd_valid held high.
      applyStimulus(0, 1, 2, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 7, 9, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 15, 15, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 4, 3, 1'b0, 1'b1, 1'b1);
      idleCycles(4);

      // Randomized commands under random backpressure.
      rr_mode = 1;
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, MOD - 1));
         b  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MOD - 1));
         um = ($urandom_range(0, 3) == 0);
         applyStimulus(op, a, b, um, 1'b1, 1'b0);
         idleCycles(int'($urandom_range(0, 2)));
      end
      cmd_valid = 1'b0;

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 500) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      if (sb.size() != 0) checkOutput("drain", sb.size(), 0);
      rr_mode = 0;
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
